// File: rtl/dwb_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : dwb_bus_if
// Brief    : CPU load/store to classic Wishbone single-transfer master bridge.
//            Optional bus timeout abort enabled by macro DWB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module dwb_bus_if #(
    parameter int CPU_STALL_IDX  = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        wb_err_o
);

    localparam logic [1:0] c_IDLE       = 2'b00;
    localparam logic [1:0] c_BUSY       = 2'b01;
    localparam logic [1:0] c_WAIT_STALL = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic        req_q, req_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic        w_timeout;
    logic        w_consumer_stalled;

    // Only one stall bit is consumed; the rest of the vector is intentionally ignored.
    logic w_unused;
    assign w_unused = ^{stall_i, 32'(TIMEOUT_CYCLES)};

    assign w_consumer_stalled = stall_i[CPU_STALL_IDX];

`ifdef DWB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               err_q, err_d;

    // Counter sits at zero while IDLE, so it is clear on every BUSY entry.
    assign w_timeout = (state_q == c_BUSY) && !wb_ack_i &&
                       (cnt_q == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = w_timeout && !flush_i;
        if (state_q != c_BUSY) begin
            cnt_d = '0;
        end else if (!wb_ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign wb_err_o = err_q;
`else
    assign w_timeout = 1'b0;
    assign wb_err_o  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            req_q    <= 1'b0;
            rd_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            req_q    <= req_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        sel_d    = sel_q;
        req_d    = req_q;
        rd_buf_d = rd_buf_q;
        case (state_q)
            c_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    state_d = c_BUSY;
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_data_i;
                    we_d    = cpu_we_i;
                    sel_d   = cpu_sel_i;
                    req_d   = 1'b1;
                end else begin
                    addr_d  = '0;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    req_d   = 1'b0;
                end
            end
            c_BUSY: begin
                if (flush_i || wb_ack_i || w_timeout) begin
                    addr_d  = '0;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    req_d   = 1'b0;
                    state_d = c_IDLE;
                    if (flush_i) begin
                        rd_buf_d = '0;
                    end else if (wb_ack_i) begin
                        rd_buf_d = wb_data_i;
                        if (w_consumer_stalled) state_d = c_WAIT_STALL;
                    end else begin
                        rd_buf_d = 32'hFFFF_FFFF;
                    end
                end
            end
            c_WAIT_STALL: begin
                if (flush_i || !w_consumer_stalled) state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
                addr_d  = '0;
                wdata_d = '0;
                we_d    = 1'b0;
                sel_d   = '0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (state_q)
            c_IDLE: stallreq_o = cpu_ce_i;
            c_BUSY: begin
                if (wb_ack_i) begin
                    cpu_data_o = wb_data_i;
                end else if (w_timeout) begin
                    cpu_data_o = 32'hFFFF_FFFF;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            c_WAIT_STALL: cpu_data_o = rd_buf_q;
            default: ;
        endcase
        if (flush_i) stallreq_o = 1'b0;
    end

    assign wb_addr_o = addr_q;
    assign wb_data_o = wdata_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_stb_o  = req_q;
    assign wb_cyc_o  = req_q;

endmodule
`default_nettype wire
